// File: rtl/tone_burst_generator.sv
// Tone burst generator: emits a square-wave burst whose half-period encodes a
// direction code, then holds a silent gap before signalling completion.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; toneOut low, busy low
// TONE  | square wave running; half/period down-counters active
// GAP   | toneOut held low for GAP_CLKS clocks, then done pulse to IDLE
module tone_burst_generator #(
  parameter int unsigned HALF_PER_1    = 12500,
  parameter int unsigned HALF_PER_2    = 8333,
  parameter int unsigned HALF_PER_3    = 6250,
  parameter int unsigned HALF_PER_4    = 5000,
  parameter int unsigned BURST_PERIODS = 200,
  parameter int unsigned GAP_CLKS      = 250000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] toneDir,
  input  logic       abort,
  output logic       toneOut,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] half_reg, half_reg_n;
  logic [CNT_W-1:0] half_cnt, half_cnt_n;
  logic [CNT_W-1:0] per_cnt, per_cnt_n;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_n;
  logic             tone_n, busy_n, done_n, err_n;
  logic [CNT_W-1:0] half_sel;
  logic             dir_ok;

  // Map the direction code onto its half-period; codes outside 1..4 are rejected.
  always_comb begin
    half_sel = '0;
    dir_ok   = 1'b1;
    case (toneDir)
      3'd1:    half_sel = CNT_W'(HALF_PER_1);
      3'd2:    half_sel = CNT_W'(HALF_PER_2);
      3'd3:    half_sel = CNT_W'(HALF_PER_3);
      3'd4:    half_sel = CNT_W'(HALF_PER_4);
      default: dir_ok   = 1'b0;
    endcase
  end

  // Next-state and next-output logic; outputs are computed here and registered below.
  always_comb begin
    state_n    = state;
    half_reg_n = half_reg;
    half_cnt_n = half_cnt;
    per_cnt_n  = per_cnt;
    gap_cnt_n  = gap_cnt;
    tone_n     = toneOut;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        tone_n = 1'b0;
        busy_n = 1'b0;
        if (start) begin
          if (dir_ok) begin
            state_n    = TONE;
            half_reg_n = half_sel;
            half_cnt_n = half_sel;
            per_cnt_n  = CNT_W'(BURST_PERIODS);
            tone_n     = 1'b1;
            busy_n     = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      TONE: begin
        if (abort) begin
          state_n = IDLE;
          tone_n  = 1'b0;
          busy_n  = 1'b0;
        end else if (half_cnt == ONE) begin
          half_cnt_n = half_reg;
          if (toneOut) begin
            tone_n = 1'b0;
          end else if (per_cnt == ONE) begin
            // Last low half finished: the gap starts on the next clock.
            state_n   = GAP;
            tone_n    = 1'b0;
            gap_cnt_n = CNT_W'(GAP_CLKS);
          end else begin
            per_cnt_n = per_cnt - ONE;
            tone_n    = 1'b1;
          end
        end else begin
          half_cnt_n = half_cnt - ONE;
        end
      end
      GAP: begin
        tone_n = 1'b0;
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (gap_cnt == ONE) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - ONE;
        end
      end
      default: begin
        state_n = IDLE;
        tone_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      half_reg <= '0;
      half_cnt <= '0;
      per_cnt  <= '0;
      gap_cnt  <= '0;
      toneOut  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      half_reg <= half_reg_n;
      half_cnt <= half_cnt_n;
      per_cnt  <= per_cnt_n;
      gap_cnt  <= gap_cnt_n;
      toneOut  <= tone_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule
